// File: rtl/sprite_mem_pkg.sv
// Shared constants and types for the sprite memory read-port arbiter.
// Also holds a pointer-width helper that stays legal for very small requester counts.
package sprite_mem_pkg;

    localparam int SPRITE_ADDR_W = 20;
    localparam int SPRITE_DATA_W = 4;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_mem_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first set request at or above
// start_ptr wins, wrapping around to index 0.
module rr_pick
    import sprite_mem_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start_ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(start_ptr) + i) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = PW'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter for the sprite memory read port, with bounded lock bursts
// and a one-cycle return path that steers read data back to the granted renderer.
module sprite_mem_arbiter
    import sprite_mem_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int ADDR_W    = SPRITE_ADDR_W,
    parameter int DATA_W    = SPRITE_DATA_W,
    parameter int MAX_BURST = 16,
    localparam int PTR_W    = ptr_w(N_REQ),
    localparam int CNT_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]       rdata,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       mem_data,
    output arb_state_t              dbg_state,
    output logic [PTR_W-1:0]        dbg_rr_ptr,
    output logic [CNT_W-1:0]        dbg_burst_cnt
);

    // Handshake: a requester holds req (and a stable addr) until it sees gnt in
    // the same cycle; that cycle is the transfer. rvalid is a single-cycle pulse
    // one cycle later with no back-pressure, so the requester must take rdata then.

    arb_state_t       state, state_nxt;
    logic [PTR_W-1:0] owner, owner_nxt;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_nxt;
    logic             inflight_valid;
    logic [PTR_W-1:0] inflight_id;

    logic [N_REQ-1:0] pick_gnt;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_holds;
    logic [PTR_W-1:0] win_idx;
    logic             win_any;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == N_REQ - 1) return '0;
        return p + 1'b1;
    endfunction

    rr_pick #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_pick (
        .req       (req),
        .start_ptr (rr_ptr),
        .gnt       (pick_gnt),
        .idx       (pick_idx),
        .any       (pick_any)
    );

    // A locked owner that drops req falls through to open arbitration this same cycle.
    assign owner_holds = (state == ARB_LOCKED) && req[owner];

    always_comb begin
        win_idx  = pick_idx;
        win_any  = pick_any;
        gnt      = '0;
        mem_addr = '0;
        if (owner_holds) begin
            win_idx = owner;
            win_any = 1'b1;
        end
        if (reset_n && win_any) begin
            if (owner_holds) gnt[owner] = 1'b1;
            else             gnt        = pick_gnt;
            mem_addr = addr[int'(win_idx)*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        burst_nxt  = burst_cnt;
        if (owner_holds) begin
            if (lock[owner] && burst_cnt != CNT_W'(MAX_BURST - 1)) begin
                burst_nxt = burst_cnt + 1'b1;
            end else begin
                state_nxt = ARB_OPEN;
                burst_nxt = '0;
            end
            rr_ptr_nxt = ptr_inc(owner);
        end else begin
            state_nxt = ARB_OPEN;
            burst_nxt = '0;
            if (pick_any) begin
                rr_ptr_nxt = ptr_inc(pick_idx);
                if (lock[pick_idx] && MAX_BURST > 1) begin
                    state_nxt = ARB_LOCKED;
                    owner_nxt = pick_idx;
                    burst_nxt = CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ARB_OPEN;
            owner          <= '0;
            rr_ptr         <= '0;
            burst_cnt      <= '0;
            inflight_valid <= 1'b0;
            inflight_id    <= '0;
        end else begin
            state          <= state_nxt;
            owner          <= owner_nxt;
            rr_ptr         <= rr_ptr_nxt;
            burst_cnt      <= burst_nxt;
            inflight_valid <= win_any;
            inflight_id    <= win_idx;
        end
    end

    always_comb begin
        rvalid = '0;
        if (inflight_valid) rvalid[inflight_id] = 1'b1;
    end

    assign rdata         = mem_data;
    assign dbg_state     = state;
    assign dbg_rr_ptr    = rr_ptr;
    assign dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench for sprite_mem_arbiter: directed scenarios plus a random run, each cycle
// checked against a rule-level model of grants and a queue of expected returns.
module tb_sprite_mem_arbiter;
    import sprite_mem_pkg::*;

    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 4;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [N-1:0]      lock;
    logic [N*AW-1:0]   addr;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [DW-1:0]     rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data;
    arb_state_t        dbg_state;
    logic [1:0]        dbg_rr_ptr;
    logic [2:0]        dbg_burst_cnt;

    logic [AW-1:0]     addr_v [N];
    logic [DW-1:0]     mem_tbl [int];

    int vectors     = 0;
    int miscompares = 0;

    // reference model: owner is -1 when the port is open
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    logic [N+DW-1:0] exp_q [$];

    logic [N-1:0]  obs_gnt;
    logic [N-1:0]  obs_rvalid;
    logic [DW-1:0] obs_rdata;
    logic [1:0]    obs_ptr;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) addr[i*AW +: AW] = addr_v[i];
    end

    function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_tbl.exists(int'(a))) return mem_tbl[int'(a)];
        return a[3:0] ^ a[11:8] ^ a[19:16] ^ 4'h6;
    endfunction

    always @(posedge clk) mem_data <= mem_read(mem_addr);

    sprite_mem_arbiter #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .lock          (lock),
        .addr          (addr),
        .gnt           (gnt),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .dbg_state     (dbg_state),
        .dbg_rr_ptr    (dbg_rr_ptr),
        .dbg_burst_cnt (dbg_burst_cnt)
    );

    // One clock cycle: drive, predict, check at the falling edge, advance model.
    task automatic cycle(input logic rst_n, input logic [N-1:0] r, input logic [N-1:0] l);
        int              win;
        logic [N-1:0]    exp_gnt;
        logic [AW-1:0]   exp_ma;
        logic [N-1:0]    exp_rv;
        logic [DW-1:0]   exp_rd;
        logic [N+DW-1:0] e;
        arb_state_t      exp_st;
        reset_n = rst_n;
        req     = r;
        lock    = l;
        win     = -1;
        if (rst_n) begin
            if (m_owner >= 0 && r[m_owner]) win = m_owner;
            else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (win < 0 && r[c]) win = c;
                end
            end
        end
        exp_gnt = '0;
        exp_ma  = '0;
        if (win >= 0) begin
            exp_gnt[win] = 1'b1;
            exp_ma       = addr_v[win];
        end
        e = '0;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL exp_q: scoreboard empty at %0t", $time);
        end else e = exp_q.pop_front();
        {exp_rv, exp_rd} = e;
        exp_st = (m_owner >= 0) ? ARB_LOCKED : ARB_OPEN;
        #4;
        obs_gnt    = gnt;
        obs_rvalid = rvalid;
        obs_rdata  = rdata;
        obs_ptr    = dbg_rr_ptr;
        vectors++;
        if (gnt !== exp_gnt) begin
            miscompares++;
            $display("FAIL gnt @%0t: got %b want %b", $time, gnt, exp_gnt);
        end
        vectors++;
        if (mem_addr !== exp_ma) begin
            miscompares++;
            $display("FAIL mem_addr @%0t: got %h want %h", $time, mem_addr, exp_ma);
        end
        vectors++;
        if (rvalid !== exp_rv) begin
            miscompares++;
            $display("FAIL rvalid @%0t: got %b want %b", $time, rvalid, exp_rv);
        end
        if (exp_rv != '0) begin
            vectors++;
            if (rdata !== exp_rd) begin
                miscompares++;
                $display("FAIL rdata @%0t: got %h want %h", $time, rdata, exp_rd);
            end
        end
        vectors++;
        if (dbg_rr_ptr !== 2'(m_ptr) || dbg_burst_cnt !== 3'(m_cnt) || dbg_state !== exp_st) begin
            miscompares++;
            $display("FAIL state @%0t: got ptr=%0d cnt=%0d st=%0d want ptr=%0d cnt=%0d st=%0d",
                     $time, dbg_rr_ptr, dbg_burst_cnt, dbg_state, m_ptr, m_cnt, exp_st);
        end
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (win >= 0 && win == m_owner) begin
            m_cnt++;
            if (!l[win] || m_cnt == MB) begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end else if (win >= 0) begin
            m_ptr = (win + 1) % N;
            if (l[win] && MB > 1) begin
                m_owner = win;
                m_cnt   = 1;
            end else begin
                m_owner = -1;
                m_cnt   = 0;
            end
        end else begin
            m_owner = -1;
            m_cnt   = 0;
        end
        exp_rv = '0;
        exp_rd = '0;
        if (win >= 0) begin
            exp_rv[win] = 1'b1;
            exp_rd      = mem_read(addr_v[win]);
        end
        exp_q.push_back({exp_rv, exp_rd});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
        cycle(1'b0, N'($urandom_range(0, 15)), N'($urandom_range(0, 15)));
    endtask

    task automatic rand_addrs();
        for (int i = 0; i < N; i++) addr_v[i] = AW'($urandom_range(0, (1 << AW) - 1));
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1'b1, 4'b0000, 4'b0000);
        vectors++;
        if (obs_rvalid !== 4'b0000 || obs_ptr !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: got rvalid=%b ptr=%0d want 0000/0", obs_rvalid, obs_ptr);
        end
    endtask

    task automatic test_single();
        do_reset();
        rand_addrs();
        addr_v[2] = 20'h00010;
        cycle(1'b1, 4'b0100, 4'b0000);
        vectors++;
        if (obs_gnt !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_gnt: got %b want 0100", obs_gnt);
        end
        cycle(1'b1, 4'b0000, 4'b0000);
        vectors++;
        if (obs_rvalid !== 4'b0100 || obs_rdata !== 4'hA) begin
            miscompares++;
            $display("FAIL single_ret: got %b/%h want 0100/a", obs_rvalid, obs_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        rand_addrs();
        for (int c = 0; c < 8; c++) begin
            cycle(1'b1, 4'b1111, 4'b0000);
            want = '0;
            want[c % N] = 1'b1;
            vectors++;
            if (obs_gnt !== want) begin
                miscompares++;
                $display("FAIL rr_order c%0d: got %b want %b", c, obs_gnt, want);
            end
        end
        cycle(1'b1, 4'b0000, 4'b0000);
        vectors++;
        if (obs_rvalid !== 4'b1000) begin
            miscompares++;
            $display("FAIL rr_tail: got %b want 1000", obs_rvalid);
        end
    endtask

    task automatic test_lock_burst();
        int           seq [7] = '{1, 1, 1, 1, 2, 0, 1};
        logic [N-1:0] pend;
        logic [N-1:0] want;
        do_reset();
        rand_addrs();
        pend = 4'b0010;
        for (int c = 0; c < 7; c++) begin
            cycle(1'b1, pend, 4'b0010);
            want = '0;
            want[seq[c]] = 1'b1;
            vectors++;
            if (obs_gnt !== want) begin
                miscompares++;
                $display("FAIL burst_seq c%0d: got %b want %b", c, obs_gnt, want);
            end
            if (c == 4) begin
                vectors++;
                if (obs_ptr !== 2'd2) begin
                    miscompares++;
                    $display("FAIL burst_release_ptr: got %0d want 2", obs_ptr);
                end
            end
            pend = (c == 0) ? 4'b0111 : ((pend & ~obs_gnt) | 4'b0010);
        end
        cycle(1'b1, 4'b0000, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000);
    endtask

    task automatic test_early_unlock();
        do_reset();
        rand_addrs();
        cycle(1'b1, 4'b1000, 4'b1000);
        cycle(1'b1, 4'b1001, 4'b1000);
        vectors++;
        if (obs_gnt !== 4'b1000 || obs_rvalid !== 4'b1000) begin
            miscompares++;
            $display("FAIL unlock_c1: got gnt=%b rv=%b want 1000/1000", obs_gnt, obs_rvalid);
        end
        cycle(1'b1, 4'b0001, 4'b0000);
        vectors++;
        if (obs_gnt !== 4'b0001 || obs_rvalid !== 4'b1000) begin
            miscompares++;
            $display("FAIL unlock_c2: got gnt=%b rv=%b want 0001/1000", obs_gnt, obs_rvalid);
        end
        cycle(1'b1, 4'b0000, 4'b0000);
        vectors++;
        if (obs_rvalid !== 4'b0001) begin
            miscompares++;
            $display("FAIL unlock_c3: got rv=%b want 0001", obs_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rand_addrs();
        cycle(1'b1, 4'b0010, 4'b0010);
        cycle(1'b1, 4'b0010, 4'b0010);
        cycle(1'b0, 4'b0110, 4'b0010);
        vectors++;
        if (obs_gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_gnt: got %b want 0000", obs_gnt);
        end
        cycle(1'b1, 4'b1000, 4'b0000);
        vectors++;
        if (obs_rvalid !== 4'b0000 || obs_gnt !== 4'b1000) begin
            miscompares++;
            $display("FAIL midreset_after: got rv=%b gnt=%b want 0000/1000", obs_rvalid, obs_gnt);
        end
        cycle(1'b1, 4'b0000, 4'b0000);
        vectors++;
        if (obs_ptr !== 2'd0 || obs_rvalid !== 4'b1000) begin
            miscompares++;
            $display("FAIL midreset_ptr: got ptr=%0d rv=%b want 0/1000", obs_ptr, obs_rvalid);
        end
    endtask

    task automatic test_idle();
        do_reset();
        rand_addrs();
        for (int c = 0; c < 10; c++) begin
            cycle(1'b1, 4'b0000, 4'b0000);
            vectors++;
            if (obs_gnt !== 4'b0000 || obs_rvalid !== 4'b0000) begin
                miscompares++;
                $display("FAIL idle c%0d: got gnt=%b rv=%b want 0000/0000", c, obs_gnt, obs_rvalid);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend;
        logic [N-1:0] lk;
        logic         rst;
        do_reset();
        rand_addrs();
        pend = '0;
        lk   = '0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) != 0);
            cycle(rst, pend, lk);
            for (int i = 0; i < N; i++) begin
                if (obs_gnt[i]) begin
                    pend[i] = ($urandom_range(0, 3) != 0);
                    if (pend[i]) addr_v[i] = AW'($urandom_range(0, (1 << AW) - 1));
                end else if (!pend[i]) begin
                    pend[i] = ($urandom_range(0, 1) == 1);
                    if (pend[i]) begin
                        addr_v[i] = AW'($urandom_range(0, (1 << AW) - 1));
                        lk[i]     = ($urandom_range(0, 2) == 0);
                    end
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req     = '0;
        lock    = '0;
        for (int i = 0; i < N; i++) addr_v[i] = '0;
        mem_tbl[32'h10] = 4'hA;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back('0);
        test_reset();
        test_single();
        test_round_robin();
        test_lock_burst();
        test_early_unlock();
        test_reset_mid();
        test_idle();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
